// File: rtl/gap_pkg.sv
// Shared types and constant helpers for the global-average-pooling sequencer.
package gap_pkg;

    // Widest beat the lane-mask helper can handle (LANES*DW must not exceed this).
    localparam int unsigned GapMaxBits = 1024;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StClear  = 3'd1,
        StAccum  = 3'd2,
        StDrain  = 3'd3,
        StOutput = 3'd4,
        StDone   = 3'd5
    } gap_state_e;

    // Beats needed to carry one channel: ceil(pix / lanes).
    function automatic int unsigned gap_beats(input int unsigned pix, input int unsigned lanes);
        return (pix + lanes - 1) / lanes;
    endfunction

    // Valid lanes in the final beat of a channel.
    function automatic int unsigned gap_rem(input int unsigned pix, input int unsigned lanes);
        return pix - (gap_beats(pix, lanes) - 1) * lanes;
    endfunction

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int unsigned gap_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Keep lanes 0..nlanes-1 of a right-aligned beat; lane 0 sits at the MSB end, so the
    // dropped lanes are the low-order ones.
    function automatic logic [GapMaxBits-1:0] gap_mask(input logic [GapMaxBits-1:0] data,
                                                       input int unsigned nlanes,
                                                       input int unsigned lanes,
                                                       input int unsigned dw);
        logic [GapMaxBits-1:0] keep;
        int unsigned           lo;
        lo   = (lanes - nlanes) * dw;
        keep = ~((GapMaxBits'(1) << lo) - GapMaxBits'(1));
        return data & keep;
    endfunction

endpackage

// File: rtl/gap_ctrl.sv
// Global-average-pooling sequencer: drives the averager's clear/add/data controls per channel,
// captures each channel's average and hands it downstream with valid/ready.
module gap_ctrl
    import gap_pkg::*;
#(
    parameter int unsigned PIX_PER_CH = 4096,
    parameter int unsigned LANES      = 9,
    parameter int unsigned DW         = 10,
    parameter int unsigned NUM_CH     = 1024,
    parameter int unsigned AVG_LAT    = 2      // must be >= 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_in_valid,
    input  logic [LANES*DW-1:0]          i_in_data,
    output logic                         o_in_ready,
    output logic                         o_avg_clr,
    output logic                         o_avg_add,
    output logic [LANES*DW-1:0]          o_avg_data,
    input  logic [DW-1:0]                i_avg_result,
    output logic                         o_out_valid,
    output logic [DW-1:0]                o_out_data,
    output logic [gap_width(NUM_CH)-1:0] o_out_ch,
    input  logic                         i_out_ready,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int unsigned BEATS = gap_beats(PIX_PER_CH, LANES);
    localparam int unsigned REM   = gap_rem(PIX_PER_CH, LANES);
    localparam int unsigned DBITS = LANES * DW;
    localparam int unsigned BW    = gap_width(BEATS);
    localparam int unsigned DRW   = gap_width(AVG_LAT + 1);
    localparam int unsigned CW    = gap_width(NUM_CH);

    localparam logic [BW-1:0]  LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [DRW-1:0] LAST_DRAIN = DRW'(AVG_LAT - 1);
    localparam logic [CW-1:0]  LAST_CH    = CW'(NUM_CH - 1);

    gap_state_e       r_state;
    gap_state_e       w_state_nxt;
    logic [CW-1:0]    r_ch;
    logic [CW-1:0]    w_ch_nxt;
    logic [BW-1:0]    r_beat;
    logic [BW-1:0]    w_beat_nxt;
    logic [DRW-1:0]   r_drain;
    logic [DRW-1:0]   w_drain_nxt;

    logic             r_avg_add;
    logic [DBITS-1:0] r_avg_data;
    logic [DW-1:0]    r_out_data;
    logic [CW-1:0]    r_out_ch;

    logic             w_hs;
    logic             w_last_beat;
    logic             w_capture;
    logic [DBITS-1:0] w_masked;

    // Handshake qualifiers and the final-beat lane mask.
    always_comb begin
        w_hs        = i_in_valid && (r_state == StAccum);
        w_last_beat = (r_beat == LAST_BEAT);
        w_masked    = DBITS'(gap_mask(GapMaxBits'(i_in_data), REM, LANES, DW));
    end

    // Next-state logic: channel/beat/drain sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_beat_nxt  = r_beat;
        w_drain_nxt = r_drain;
        w_capture   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StClear;
                    w_ch_nxt    = '0;
                end
            end
            StClear: begin
                w_beat_nxt  = '0;
                w_state_nxt = StAccum;
            end
            StAccum: begin
                if (i_in_valid) begin
                    if (w_last_beat) begin
                        w_drain_nxt = '0;
                        w_state_nxt = StDrain;
                    end else begin
                        w_beat_nxt = r_beat + BW'(1);
                    end
                end
            end
            StDrain: begin
                // The averager samples the last add on the first DRAIN edge; its result is
                // ready to be captured on the AVG_LAT-th DRAIN edge.
                if (r_drain == LAST_DRAIN) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StOutput;
                end else begin
                    w_drain_nxt = r_drain + DRW'(1);
                end
            end
            StOutput: begin
                if (i_out_ready) begin
                    if (r_ch == LAST_CH) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_ch_nxt    = r_ch + CW'(1);
                        w_state_nxt = StClear;
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and counter registers; reset aborts any frame in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_ch    <= '0;
            r_beat  <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_beat  <= w_beat_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    // Registered averager controls: one add per accepted beat, last beat masked.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_avg_add  <= 1'b0;
            r_avg_data <= '0;
        end else begin
            r_avg_add <= w_hs;
            if (w_hs) begin
                r_avg_data <= w_last_beat ? w_masked : i_in_data;
            end
        end
    end

    // Result capture; held unchanged for the whole OUTPUT stall.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_data <= '0;
            r_out_ch   <= '0;
        end else if (w_capture) begin
            r_out_data <= i_avg_result;
            r_out_ch   <= r_ch;
        end
    end

    // State-decoded outputs.
    always_comb begin
        o_in_ready  = (r_state == StAccum);
        o_avg_clr   = (r_state == StClear);
        o_out_valid = (r_state == StOutput);
        o_done      = (r_state == StDone);
        o_busy      = (r_state != StIdle);
        o_avg_add   = r_avg_add;
        o_avg_data  = r_avg_data;
        o_out_data  = r_out_data;
        o_out_ch    = r_out_ch;
    end

endmodule

// File: tb/tb_gap_ctrl.sv
// Randomized self-checking bench for gap_ctrl with a behavioural averager and reference model.
module tb_gap_ctrl;

    localparam int unsigned P_PIX     = 4096;
    localparam int unsigned P_LANES   = 9;
    localparam int unsigned P_DW      = 10;
    localparam int unsigned P_NCH     = 3;
    localparam int unsigned P_LAT     = 2;
    localparam int unsigned DBITS     = P_LANES * P_DW;
    localparam int unsigned CW        = 2;
    localparam int unsigned REF_BEATS = (P_PIX + P_LANES - 1) / P_LANES;
    localparam int unsigned PERIOD    = 1 + REF_BEATS + P_LAT + 1;
    localparam int          BUDGET    = 20000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [DBITS-1:0] in_data;
    logic             in_ready;
    logic             avg_clr;
    logic             avg_add;
    logic [DBITS-1:0] avg_data;
    logic [P_DW-1:0]  avg_result;
    logic             out_valid;
    logic [P_DW-1:0]  out_data;
    logic [CW-1:0]    out_ch;
    logic             out_ready;
    logic             busy;
    logic             done;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    gap_ctrl #(
        .PIX_PER_CH (P_PIX),
        .LANES      (P_LANES),
        .DW         (P_DW),
        .NUM_CH     (P_NCH),
        .AVG_LAT    (P_LAT)
    ) u_dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_avg_clr    (avg_clr),
        .o_avg_add    (avg_add),
        .o_avg_data   (avg_data),
        .i_avg_result (avg_result),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .o_out_ch     (out_ch),
        .i_out_ready  (out_ready),
        .o_busy       (busy),
        .o_done       (done)
    );

    function automatic longint unsigned lane_sum(input logic [DBITS-1:0] d);
        longint unsigned s;
        s = 0;
        for (int l = 0; l < int'(P_LANES); l++) begin
            s += longint'(d[(int'(P_LANES) - l) * int'(P_DW) - 1 -: P_DW]);
        end
        return s;
    endfunction

    // Behavioural averager: sums on each add, result is the floored mean of one channel and
    // reflects the final add from the edge that samples it.
    longint unsigned acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 0;
        end else if (avg_clr) begin
            acc <= 0;
        end else if (avg_add) begin
            acc <= acc + lane_sum(avg_data);
        end
    end
    assign avg_result = P_DW'(acc / P_PIX);

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet();
        check_eq("rst_in_ready", 128'(in_ready), 128'(0));
        check_eq("rst_avg_clr", 128'(avg_clr), 128'(0));
        check_eq("rst_avg_add", 128'(avg_add), 128'(0));
        check_eq("rst_avg_data", 128'(avg_data), 128'(0));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_out_data", 128'(out_data), 128'(0));
        check_eq("rst_out_ch", 128'(out_ch), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_done", 128'(done), 128'(0));
    endtask

    // dmode: 0 all 8, 1 lane0 255 / others 200, 2 channel number + 1, 3 random
    function automatic int unsigned pix_val(input int dmode, input int ch, input int unsigned idx);
        case (dmode)
            0:       return 8;
            1:       return ((idx % P_LANES) == 0) ? 255 : 200;
            2:       return int'(ch) + 1;
            default: return $urandom_range(0, 1023);
        endcase
    endfunction

    // vmode: 0 continuous valid, 1 random 50%
    // rmode: 0 ready always, 1 random, 2 low for the first 10 valid cycles of each result
    // abort_at: handshake number at which reset is asserted instead (-1 = never)
    task automatic run_frame(input int vmode, input int rmode, input int dmode, input int abort_at);
        int                    n, beat, ch_in, out_idx, n_add, n_clr, last_clr, acc_n;
        int                    hs_total, vcnt;
        bit                    finished, aborted, held;
        longint unsigned       sum;
        int unsigned           v, idx;
        logic [DBITS-1:0]      beat_data, exp_beat;
        logic [DBITS-1:0]      exp_add_q[$];
        int unsigned           exp_res_q[$];
        n = 0; beat = 0; ch_in = 0; out_idx = 0; n_add = 0; n_clr = 0; last_clr = 0;
        acc_n = -10; hs_total = 0; vcnt = 0; finished = 0; aborted = 0; held = 0; sum = 0;
        exp_add_q.delete();
        exp_res_q.delete();

        @(negedge clk);
        start = 1'b1;
        while (!finished && !aborted && n < BUDGET) begin
            @(negedge clk);
            n++;
            // observe
            if (avg_add) begin
                n_add++;
                if (exp_add_q.size() == 0) begin
                    check_eq("add_unexpected", 128'(avg_add), 128'(0));
                end else begin
                    check_eq("avg_data", 128'(avg_data), 128'(exp_add_q.pop_front()));
                end
            end
            if (avg_clr) begin
                n_clr++;
                check_eq("clr_in_ready", 128'(in_ready), 128'(0));
                if (n_clr == 1) begin
                    check_eq("clr_first", 128'(n), 128'(1));
                end else if (vmode == 0 && rmode == 0) begin
                    check_eq("ch_period", 128'(n - last_clr), 128'(PERIOD));
                end
                last_clr = n;
            end
            if (held) check_eq("hold_valid", 128'(out_valid), 128'(1));
            if (out_valid) begin
                vcnt++;
                check_eq("out_in_ready", 128'(in_ready), 128'(0));
                check_eq("out_clr", 128'(avg_clr), 128'(0));
                if (out_idx < exp_res_q.size()) begin
                    check_eq("out_data", 128'(out_data), 128'(exp_res_q[out_idx]));
                    check_eq("out_ch", 128'(out_ch), 128'(out_idx));
                end else begin
                    check_eq("out_unexpected", 128'(out_valid), 128'(0));
                end
            end else begin
                vcnt = 0;
            end
            if (done) begin
                check_eq("done_lat", 128'(n), 128'(acc_n + 1));
                check_eq("done_out_count", 128'(out_idx), 128'(P_NCH));
                finished = 1;
            end

            // drive
            start    = (!finished && $urandom_range(0, 24) == 0);
            in_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            exp_beat = '0;
            sum      = sum;
            for (int l = 0; l < int'(P_LANES); l++) begin
                idx = int'(beat) * P_LANES + l;
                v   = pix_val(dmode, ch_in, idx);
                beat_data[(int'(P_LANES) - l) * int'(P_DW) - 1 -: P_DW] = v[P_DW-1:0];
                if (idx < P_PIX) begin
                    exp_beat[(int'(P_LANES) - l) * int'(P_DW) - 1 -: P_DW] = v[P_DW-1:0];
                end
            end
            in_data = beat_data;
            if (in_valid && in_ready) begin
                hs_total++;
                if (hs_total == abort_at) begin
                    rst      = 1'b1;
                    in_valid = 1'b0;
                    start    = 1'b0;
                    #1;
                    check_quiet();
                    @(negedge clk);
                    rst     = 1'b0;
                    aborted = 1;
                end else begin
                    exp_add_q.push_back(exp_beat);
                    sum += lane_sum(exp_beat);
                    beat++;
                    if (beat * int'(P_LANES) >= int'(P_PIX)) begin
                        exp_res_q.push_back(int'(sum / P_PIX));
                        sum = 0;
                        beat = 0;
                        ch_in++;
                    end
                end
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (vcnt > 10);
            endcase
            held = out_valid && !out_ready;
            if (out_valid && out_ready) begin
                out_idx++;
                acc_n = n;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;

        if (!aborted) begin
            check_eq("frame_done", 128'(finished), 128'(1));
            check_eq("add_count", 128'(n_add), 128'(REF_BEATS * P_NCH));
            check_eq("clr_count", 128'(n_clr), 128'(P_NCH));
            check_eq("add_left", 128'(exp_add_q.size()), 128'(0));
            @(negedge clk);
            check_eq("idle_busy", 128'(busy), 128'(0));
            check_eq("idle_done", 128'(done), 128'(0));
            check_eq("idle_out_valid", 128'(out_valid), 128'(0));
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check_quiet();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet();

        run_frame(0, 0, 0, -1);   // all 8, continuous
        run_frame(0, 0, 1, -1);   // lane0 255, others 200 -> 206
        run_frame(1, 1, 0, -1);   // bubbles on input, random ready
        run_frame(0, 2, 2, -1);   // 10-cycle output stall, channel values 1,2,3
        run_frame(0, 0, 0, 100);  // reset mid-channel
        run_frame(1, 0, 0, -1);   // restart after abort
        run_frame(1, 1, 3, -1);   // random pixels

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
